// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: prediction modes
// and direction-counter encodings.
package bp_pkg;

    localparam int unsigned BP_BIMODAL = 0;
    localparam int unsigned BP_GSHARE  = 1;

    // Weakly taken: MSB set, all lower bits clear.
    function automatic logic [31:0] ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic logic [31:0] ctr_weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-value function for an n-bit saturating up/down counter.
module bp_sat_ctr #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] ctr_i,
    input  logic         up_i,
    output logic [W-1:0] ctr_o
);

    // NOTE: assigning a default first keeps this combinational block latch-free.
    always_comb begin
        ctr_o = ctr_i;
        if (up_i && (ctr_i != '1)) begin
            ctr_o = ctr_i + W'(1);
        end else if (!up_i && (ctr_i != '0)) begin
            ctr_o = ctr_i - W'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry direction counters, bimodal or gshare
// indexing, and a saturating count of committed mispredicts.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned PRED_MODE = 0,
    parameter int unsigned GHR_W     = 4,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned IDX_W    = $clog2(ENTRIES)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             pred_hit_o,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [XLEN-1:0]  upd_pc_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic [XLEN-1:0]  upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [XLEN-1:0]  upd_pred_target_i,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    logic [ENTRIES-1:0] valid_q;
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] lk_idx;
    entry_t           lk_entry;

    always_comb begin
        lk_idx   = if_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
        lk_entry = '{valid_q[lk_idx], tag_q[lk_idx], target_q[lk_idx], ctr_q[lk_idx]};
    end

    assign pred_idx_o    = lk_idx;
    assign pred_hit_o    = lk_entry.valid && (lk_entry.tag == if_pc_i[XLEN-1:IDX_W+2]);
    assign pred_taken_o  = pred_hit_o && lk_entry.ctr[CTR_W-1];
    assign pred_target_o = pred_taken_o ? lk_entry.target : if_pc_i + XLEN'(4);

    // ---------------- update ----------------
    entry_t           up_entry;
    logic             up_hit;
    logic             commit;
    logic [CTR_W-1:0] ctr_next;
    logic             unused_upd_pc_lo;

    assign up_entry = '{valid_q[upd_idx_i], tag_q[upd_idx_i], target_q[upd_idx_i], ctr_q[upd_idx_i]};
    assign up_hit   = up_entry.valid && (up_entry.tag == upd_pc_i[XLEN-1:IDX_W+2]);
    assign commit   = upd_valid_i && !stall_i;
    // The update index travels down the pipe with the instruction, so only the tag bits of upd_pc_i matter.
    assign unused_upd_pc_lo = ^upd_pc_i[IDX_W+1:0];

    assign mispredict_o = upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    bp_sat_ctr #(.W(CTR_W)) u_sat_ctr (
        .ctr_i (up_entry.ctr),
        .up_i  (upd_taken_i),
        .ctr_o (ctr_next)
    );

    // NOTE: tag and target storage carry no reset; valid bits alone gate their use,
    // which keeps these arrays mappable to plain RAM.
    always_ff @(posedge CLK) begin
        if (commit && upd_taken_i) begin
            tag_q[upd_idx_i]    <= upd_pc_i[XLEN-1:IDX_W+2];
            target_q[upd_idx_i] <= upd_target_i;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every reader in the same edge sees the pre-update value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (commit) begin
            if (up_hit) begin
                ctr_q[upd_idx_i] <= ctr_next;
            end else if (upd_taken_i) begin
                valid_q[upd_idx_i] <= 1'b1;
                ctr_q[upd_idx_i]   <= CTR_WT;
            end
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        cnt_d = cnt_q;
        if (commit) begin
            if (PRED_MODE == BP_GSHARE) begin
                ghr_d = GHR_W'({ghr_q, upd_taken_i});
            end
            if (mispredict_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ghr_q <= '0;
            cnt_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            cnt_q <= cnt_d;
        end
    end

    assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Random and directed stimulus on a bimodal and a gshare instance, checked
// against a table-level reference model of the predictor.
module tb_branch_target_predictor;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic        stall, upd_valid, upd_taken, upd_pred_taken;
    logic [31:0] if_pc, upd_pc, upd_target, upd_pred_target;
    logic [1:0][3:0]  upd_idx;
    logic [1:0]       hit, taken, mis;
    logic [1:0][31:0] tgt;
    logic [1:0][3:0]  pidx;
    logic [3:0]  cnt_b;
    logic [15:0] cnt_g;

    branch_target_predictor #(.PRED_MODE(0), .CNT_W(4)) u_bim (
        .CLK(CLK), .RST(RST), .stall_i(stall), .if_pc_i(if_pc),
        .pred_hit_o(hit[0]), .pred_taken_o(taken[0]), .pred_target_o(tgt[0]),
        .pred_idx_o(pidx[0]), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
        .upd_idx_i(upd_idx[0]), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
        .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
        .mispredict_o(mis[0]), .mispred_cnt_o(cnt_b)
    );

    branch_target_predictor #(.PRED_MODE(1), .GHR_W(4), .CNT_W(16)) u_gsh (
        .CLK(CLK), .RST(RST), .stall_i(stall), .if_pc_i(if_pc),
        .pred_hit_o(hit[1]), .pred_taken_o(taken[1]), .pred_target_o(tgt[1]),
        .pred_idx_o(pidx[1]), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
        .upd_idx_i(upd_idx[1]), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
        .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
        .mispredict_o(mis[1]), .mispred_cnt_o(cnt_g)
    );

    // ---------------- reference model ----------------
    bit          mvalid [2][16];
    logic [31:0] mtag   [2][16];
    logic [31:0] mtgt   [2][16];
    int          mctr   [2][16];
    int          mghr   [2];
    int          mcnt   [2];
    int          cnt_max[2] = '{15, 65535};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic void m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                mvalid[m][i] = 1'b0;
                mctr[m][i]   = 1;
            end
            mghr[m] = 0;
            mcnt[m] = 0;
        end
    endfunction

    function automatic int m_idx(input int m, input logic [31:0] pc);
        int i = int'((pc >> 2) % 16);
        if (m == 1) i = i ^ mghr[m];
        return i;
    endfunction

    function automatic void m_lookup(input int m, input logic [31:0] pc,
                                     output bit h, output bit t, output logic [31:0] tg);
        int i = m_idx(m, pc);
        h  = mvalid[m][i] && (mtag[m][i] == (pc >> 6));
        t  = h && (mctr[m][i] >= 2);
        tg = t ? mtgt[m][i] : pc + 32'd4;
    endfunction

    function automatic bit exp_mis();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    function automatic void m_update(input int m);
        int i = int'(upd_idx[m]);
        bit h = mvalid[m][i] && (mtag[m][i] == (upd_pc >> 6));
        if (h) begin
            if (upd_taken) begin
                mctr[m][i] = (mctr[m][i] < 3) ? mctr[m][i] + 1 : 3;
                mtgt[m][i] = upd_target;
            end else begin
                mctr[m][i] = (mctr[m][i] > 0) ? mctr[m][i] - 1 : 0;
            end
        end else if (upd_taken) begin
            mvalid[m][i] = 1'b1;
            mtag[m][i]   = upd_pc >> 6;
            mtgt[m][i]   = upd_target;
            mctr[m][i]   = 2;
        end
        if (m == 1) mghr[m] = ((mghr[m] << 1) | int'(upd_taken)) % 16;
        if (exp_mis()) mcnt[m] = (mcnt[m] < cnt_max[m]) ? mcnt[m] + 1 : cnt_max[m];
    endfunction

    task automatic compare_all();
        bit h, t;
        logic [31:0] tg;
        for (int m = 0; m < 2; m++) begin
            m_lookup(m, if_pc, h, t, tg);
            check($sformatf("m%0d hit pc=%0h", m, if_pc), 64'(hit[m]), 64'(h));
            check($sformatf("m%0d taken pc=%0h", m, if_pc), 64'(taken[m]), 64'(t));
            check($sformatf("m%0d target pc=%0h", m, if_pc), 64'(tgt[m]), 64'(tg));
            check($sformatf("m%0d idx pc=%0h", m, if_pc), 64'(pidx[m]), 64'(m_idx(m, if_pc)));
            check($sformatf("m%0d mispredict", m), 64'(mis[m]), 64'(exp_mis()));
            check($sformatf("m%0d cnt", m), (m == 0) ? 64'(cnt_b) : 64'(cnt_g), 64'(mcnt[m]));
        end
    endtask

    // Apply one cycle of inputs at the falling edge, check the pre-edge view,
    // then commit the model at the rising edge. Returns at the next falling edge.
    task automatic drive(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utgt, input bit upt,
                         input logic [31:0] uptgt, input bit st, input int idx_ovr);
        if_pc = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pred_taken = upt; upd_pred_target = uptgt; stall = st;
        for (int m = 0; m < 2; m++)
            upd_idx[m] = (idx_ovr >= 0) ? 4'(idx_ovr) : 4'(m_idx(m, upc));
        #2;
        compare_all();
        @(posedge CLK);
        if (uv && !st) begin
            for (int m = 0; m < 2; m++) m_update(m);
        end
        @(negedge CLK);
    endtask

    task automatic look(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] bases[3] = '{32'h0000_0000, 32'h0000_1000, 32'hFFFF_FF00};
        return bases[$urandom_range(0, 2)] + (32'($urandom_range(0, 31)) << 2);
    endfunction

    bit dirs[7]      = '{0, 0, 1, 1, 1, 1, 0};
    bit exp_taken[7] = '{0, 0, 0, 1, 1, 1, 1};

    initial begin
        RST = 1'b1; stall = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; if_pc = 32'h100;
        upd_idx = '0;
        m_reset();
        #12 RST = 1'b0;
        @(negedge CLK);

        // reset state
        look(32'h100);
        check("reset hit", 64'(hit[0]), 64'd0);
        check("reset taken", 64'(taken[0]), 64'd0);
        check("reset target", 64'(tgt[0]), 64'h104);
        check("reset cnt", 64'(cnt_b), 64'd0);

        // allocate 0x100 -> 0x80; the same-cycle lookup is checked inside drive
        drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, -1);
        check("alloc hit", 64'(hit[0]), 64'd1);
        check("alloc taken", 64'(taken[0]), 64'd1);
        check("alloc target", 64'(tgt[0]), 64'h80);

        // counter walk 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
        for (int k = 0; k < 7; k++) begin
            drive(32'h100, 1, 32'h100, dirs[k], 32'h80, 1, 32'h80, 0, -1);
            check($sformatf("ctr walk %0d taken", k), 64'(taken[0]), 64'(exp_taken[k]));
            check($sformatf("ctr walk %0d hit", k), 64'(hit[0]), 64'd1);
        end

        // aliasing: 0x140 shares index 0 with 0x100
        look(32'h140);
        check("alias miss", 64'(hit[0]), 64'd0);
        drive(32'h140, 1, 32'h140, 1, 32'h200, 0, 32'h144, 0, -1);
        look(32'h100);
        check("replaced old miss", 64'(hit[0]), 64'd0);
        look(32'h140);
        check("replaced new target", 64'(tgt[0]), 64'h200);

        // stalled update leaves the counter alone
        drive(32'h140, 1, 32'h140, 0, 32'h0, 1, 32'h200, 1, -1);
        check("stall taken held", 64'(taken[0]), 64'd1);

        // 17 mispredicting updates saturate the 4-bit counter
        for (int k = 0; k < 17; k++)
            drive(32'h140, 1, 32'h300, 0, 32'h0, 1, 32'h400, 0, -1);
        check("cnt saturate", 64'(cnt_b), 64'd15);

        // asynchronous reset mid-update
        if_pc = 32'h140; upd_valid = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1;
        upd_target = 32'h500; upd_pred_taken = 1'b0; upd_pred_target = 32'h144;
        #3 RST = 1'b1;
        #1;
        m_reset();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d async rst hit", m), 64'(hit[m]), 64'd0);
            check($sformatf("m%0d async rst target", m), 64'(tgt[m]), 64'h144);
        end
        check("async rst cnt b", 64'(cnt_b), 64'd0);
        check("async rst cnt g", 64'(cnt_g), 64'd0);
        @(posedge CLK);
        #2 RST = 1'b0; upd_valid = 1'b0;
        @(negedge CLK);

        // PC+4 wraps
        look(32'hFFFF_FFFC);
        check("wrap target", 64'(tgt[0]), 64'h0);

        // gshare: two taken updates -> ghr=0011
        drive(32'h100, 1, 32'h200, 1, 32'h400, 1, 32'h400, 0, -1);
        drive(32'h100, 1, 32'h200, 1, 32'h400, 1, 32'h400, 0, -1);
        check("gshare idx", 64'(pidx[1]), 64'd3);
        drive(32'h100, 1, 32'h100, 1, 32'h180, 0, 32'h104, 0, 3);
        // ghr is now 0111; 0x110 carries the same tag and folds onto index 3
        look(32'h110);
        check("gshare hit", 64'(hit[1]), 64'd1);
        check("gshare idx2", 64'(pidx[1]), 64'd3);
        check("gshare target", 64'(tgt[1]), 64'h180);

        // randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            logic [31:0] upc, utgt, uptgt;
            bit h, t, upt;
            logic [31:0] ptg;
            int ovr;
            upc  = rand_pc();
            utgt = 32'($urandom) & 32'hFFFF_FFFC;
            m_lookup(0, upc, h, t, ptg);
            upt   = t;
            uptgt = ptg;
            if ($urandom_range(0, 9) < 3) begin
                upt   = 1'($urandom);
                uptgt = 32'($urandom) & 32'hFFFF_FFFC;
            end
            if (($urandom_range(0, 9) < 5) && h) utgt = ptg;
            ovr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
            drive(rand_pc(), ($urandom_range(0, 9) < 6), upc, 1'($urandom), utgt,
                  upt, uptgt, ($urandom_range(0, 9) == 0), ovr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
